// File: rtl/song_sequencer.sv
// song_sequencer: walks a synchronous song ROM and hands one {note, duration}
// entry at a time to the note player, waiting for the player's done pulse
// before fetching the next entry. Flags the end of each song.
//
// Build option: define SEQ_LOOP_EN to make a song repeat from entry 0 at its
// end (end marker or last index) instead of returning to IDLE. song_done
// still pulses on every end of song.
//
// Handshake: load_new_note is a one-cycle strobe with no ready. The note and
// duration outputs are stable in that cycle and hold until the next capture.
// note_done is a one-cycle completion pulse from the player. It is only
// honoured in PLAYING while play is high; everywhere else it is dropped.
module song_sequencer #(
  parameter int SONG_W = 2,
  parameter int IDX_W  = 5,
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      play,
  input  logic [SONG_W-1:0]         song,
  output logic [SONG_W+IDX_W-1:0]   rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]   rom_data,
  input  logic                      note_done,
  output logic [NOTE_W-1:0]         note_to_load,
  output logic [DUR_W-1:0]          duration_to_load,
  output logic                      load_new_note,
  output logic                      song_done,
  output logic [2:0]                o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_RDATA   = 3'd2,
    S_LOAD    = 3'd3,
    S_PLAYING = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_next_state;
  logic                r_play_q;
  logic                r_armed;
  logic [SONG_W-1:0]   r_song_q;
  logic [IDX_W-1:0]    r_idx;
  logic [NOTE_W-1:0]   r_note;
  logic [DUR_W-1:0]    r_dur;

  logic                w_start;
  logic                w_song_chg;
  logic                w_last_idx;
  logic                w_end_marker;
  logic [NOTE_W-1:0]   w_rom_note;
  logic [DUR_W-1:0]    w_rom_dur;
  logic                w_latch_song;
  logic                w_idx_inc;
  logic                w_idx_clr;
  logic                w_capture;
  logic                w_song_done;

  assign w_rom_note   = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign w_rom_dur    = rom_data[DUR_W-1:0];
  assign w_end_marker = (w_rom_dur == '0);
  assign w_last_idx   = &r_idx;
  assign w_song_chg   = (song != r_song_q);
  // r_armed stays low until play has been seen low after reset, so a play
  // level held high across reset is not mistaken for a fresh rising edge.
  assign w_start      = play & ~r_play_q & r_armed;

  assign rom_addr         = {r_song_q, r_idx};
  assign note_to_load     = r_note;
  assign duration_to_load = r_dur;
  assign load_new_note    = (r_state == S_LOAD);
  assign song_done        = w_song_done;
  assign o_dbg_state      = r_state;

  // Play edge detector and post-reset arming.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_play_q <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      r_play_q <= play;
      if (!play) r_armed <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state and control decode; a song change outranks everything else
  // once a song is running.
  always_comb begin
    w_next_state = r_state;
    w_latch_song = 1'b0;
    w_idx_inc    = 1'b0;
    w_idx_clr    = 1'b0;
    w_capture    = 1'b0;
    w_song_done  = 1'b0;
    if (r_state != S_IDLE && w_song_chg) begin
      w_latch_song = 1'b1;
      w_next_state = S_FETCH;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            w_latch_song = 1'b1;
            w_next_state = S_FETCH;
          end
        end
        S_FETCH: w_next_state = S_RDATA;
        S_RDATA: begin
          if (w_end_marker) begin
            w_song_done = 1'b1;
`ifdef SEQ_LOOP_EN
            w_idx_clr    = 1'b1;
            w_next_state = S_FETCH;
`else
            w_next_state = S_IDLE;
`endif
          end else begin
            w_capture    = 1'b1;
            w_next_state = S_LOAD;
          end
        end
        S_LOAD: w_next_state = S_PLAYING;
        S_PLAYING: begin
          if (note_done && play) begin
            if (w_last_idx) begin
              w_song_done = 1'b1;
`ifdef SEQ_LOOP_EN
              w_idx_clr    = 1'b1;
              w_next_state = S_FETCH;
`else
              w_next_state = S_IDLE;
`endif
            end else begin
              w_idx_inc    = 1'b1;
              w_next_state = S_FETCH;
            end
          end
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Song select and entry index that form the ROM address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_song_q <= '0;
      r_idx    <= '0;
    end else if (w_latch_song) begin
      r_song_q <= song;
      r_idx    <= '0;
    end else if (w_idx_clr) begin
      r_idx <= '0;
    end else if (w_idx_inc) begin
      r_idx <= r_idx + IDX_ONE;
    end
  end

  // Note/duration holding registers for the player.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_note <= '0;
      r_dur  <= '0;
    end else if (w_capture) begin
      r_note <= w_rom_note;
      r_dur  <= w_rom_dur;
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
module tb_song_sequencer;
  localparam int SONG_W = 2;
  localparam int IDX_W  = 5;
  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;
  localparam int AW     = SONG_W + IDX_W;
  localparam int DW     = NOTE_W + DUR_W;
  localparam int NENT   = 1 << IDX_W;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PLAYING = 3'd4;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset_n;
  logic              play;
  logic [SONG_W-1:0] song;
  logic [AW-1:0]     rom_addr;
  logic [DW-1:0]     rom_data;
  logic              note_done;
  logic [NOTE_W-1:0] note_to_load;
  logic [DUR_W-1:0]  duration_to_load;
  logic              load_new_note;
  logic              song_done;
  logic [2:0]        dbg_state;

  always #5 clk = ~clk;

  song_sequencer #(.SONG_W(SONG_W), .IDX_W(IDX_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) dut (
    .clk(clk), .reset_n(reset_n), .play(play), .song(song), .rom_addr(rom_addr),
    .rom_data(rom_data), .note_done(note_done), .note_to_load(note_to_load),
    .duration_to_load(duration_to_load), .load_new_note(load_new_note),
    .song_done(song_done), .o_dbg_state(dbg_state)
  );

  // Synchronous song ROM, one cycle of read latency.
  logic [DW-1:0] rom_mem [0:(1<<AW)-1];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int n_loads  = 0;
  int n_dones  = 0;
  int n_both   = 0;

  // Event counters sampled mid-cycle.
  always @(negedge clk) begin
    if (load_new_note) n_loads = n_loads + 1;
    if (song_done) n_dones = n_dones + 1;
    if (load_new_note && song_done) n_both = n_both + 1;
  end

  // ---------------- reference model ----------------
  // Number of playable entries before the first zero-duration marker.
  function automatic int song_len(input int s);
    logic [DW-1:0] e;
    for (int k = 0; k < NENT; k++) begin
      e = rom_mem[s*NENT + k];
      if (e[DUR_W-1:0] == '0) return k;
    end
    return NENT;
  endfunction

  function automatic logic [DW-1:0] entry(input int s, input int k);
    return rom_mem[s*NENT + k];
  endfunction

  function automatic logic [AW-1:0] addr_of(input int s, input int k);
    return {SONG_W'(s), IDX_W'(k)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n   = 1'b0;
    play      = 1'b0;
    note_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    next_cycle();
  endtask

  task automatic pulse_note_done();
    note_done = 1'b1;
    next_cycle();
    note_done = 1'b0;
  endtask

  // Called at a drive point; lat = cycles until the strobe cycle, -1 on timeout.
  // Returns at the negedge of the strobe cycle.
  task automatic wait_load(output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      if (load_new_note) return;
      if (lat >= 20) begin
        lat = -1;
        return;
      end
      next_cycle();
      lat++;
    end
  endtask

  task automatic fill_rom();
    int m0, n2;
    for (int a = 0; a < (1 << AW); a++)
      rom_mem[a] = {NOTE_W'($urandom_range(0, 63)), DUR_W'($urandom_range(1, 63))};
    m0 = $urandom_range(0, 2);
    rom_mem[m0] = {NOTE_W'($urandom_range(0, 63)), DUR_W'(0)};
    rom_mem[NENT + 0] = {NOTE_W'(5), DUR_W'(10)};
    rom_mem[NENT + 4] = {NOTE_W'($urandom_range(0, 63)), DUR_W'(0)};
    n2 = $urandom_range(3, 6);
    rom_mem[2*NENT + n2] = {NOTE_W'($urandom_range(0, 63)), DUR_W'(0)};
    rom_mem[2*NENT + 1] = {NOTE_W'(0), DUR_W'($urandom_range(1, 63))};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; play = 1'b0; note_done = 1'b0; song = '0;
    #3;
    checks++; if (load_new_note !== 1'b0) begin failures++; $display("FAIL reset_load: got %0b expected 0", load_new_note); end
    checks++; if (song_done !== 1'b0) begin failures++; $display("FAIL reset_song_done: got %0b expected 0", song_done); end
    checks++; if (note_to_load !== '0 || duration_to_load !== '0) begin failures++; $display("FAIL reset_note_dur: got %0d/%0d expected 0/0", note_to_load, duration_to_load); end
    checks++; if (rom_addr !== '0) begin failures++; $display("FAIL reset_rom_addr: got %0h expected 0", rom_addr); end
    checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    apply_reset();
    note_done = 1'b1;
    repeat (3) next_cycle();
    note_done = 1'b0;
    @(negedge clk);
    checks++; if (dbg_state !== ST_IDLE || n_loads !== 0) begin failures++; $display("FAIL idle_ignores_done: state %0d loads %0d expected %0d/0", dbg_state, n_loads, ST_IDLE); end
  endtask

  task automatic test_first_load();
    logic [AW-1:0] ea;
    apply_reset();
    song = 2'd1;
    next_cycle();
    play = 1'b1;                       // cycle 0: rising edge sampled
    @(negedge clk);
    checks++; if (load_new_note !== 1'b0) begin failures++; $display("FAIL first_c0_load: got %0b expected 0", load_new_note); end
    next_cycle(); @(negedge clk);      // cycle 1
    ea = addr_of(1, 0);
    checks++; if (rom_addr !== ea) begin failures++; $display("FAIL first_c1_addr: got %0h expected %0h", rom_addr, ea); end
    next_cycle(); @(negedge clk);      // cycle 2
    checks++; if (load_new_note !== 1'b0) begin failures++; $display("FAIL first_c2_load: got %0b expected 0", load_new_note); end
    next_cycle(); @(negedge clk);      // cycle 3
    checks++; if (load_new_note !== 1'b1) begin failures++; $display("FAIL first_c3_load: got %0b expected 1", load_new_note); end
    checks++; if (note_to_load !== 6'd5 || duration_to_load !== 6'd10) begin failures++; $display("FAIL first_c3_data: got %0d/%0d expected 5/10", note_to_load, duration_to_load); end
    next_cycle();
  endtask

  task automatic test_song_end(input int s);
    int len, lat, l0, d0;
    logic [DW-1:0] got, exp;
    logic [AW-1:0] ea;
    apply_reset();
    song = SONG_W'(s);
    next_cycle();
    len = song_len(s);
    exp_q.delete();
    for (int k = 0; k < len; k++) exp_q.push_back(entry(s, k));
    l0 = n_loads; d0 = n_dones;
    play = 1'b1;
    next_cycle();
    for (int k = 0; k < len; k++) begin
      wait_load(lat);
      checks++; if (lat !== 2) begin failures++; $display("FAIL end_latency s%0d i%0d: got %0d expected 2", s, k, lat); end
      got = {note_to_load, duration_to_load};
      exp = exp_q.pop_front();
      checks++; if (got !== exp) begin failures++; $display("FAIL end_data s%0d i%0d: got %0h expected %0h", s, k, got, exp); end
      next_cycle();
      repeat ($urandom_range(0, 3)) next_cycle();
      pulse_note_done();
    end
    next_cycle(); @(negedge clk);      // marker in RDATA
    checks++; if (song_done !== 1'b1 || load_new_note !== 1'b0) begin failures++; $display("FAIL end_pulse s%0d: done %0b load %0b expected 1/0", s, song_done, load_new_note); end
    next_cycle(); @(negedge clk);
`ifdef SEQ_LOOP_EN
    ea = addr_of(s, 0);
    checks++; if (rom_addr !== ea) begin failures++; $display("FAIL end_wrap_addr s%0d: got %0h expected %0h", s, rom_addr, ea); end
    checks++; if (n_loads - l0 !== len || n_dones - d0 !== 1) begin failures++; $display("FAIL end_counts s%0d: loads %0d dones %0d expected %0d/1", s, n_loads - l0, n_dones - d0, len); end
    if (len > 0) begin
      next_cycle();
      wait_load(lat);
      got = {note_to_load, duration_to_load};
      exp = entry(s, 0);
      checks++; if (lat !== 1 || got !== exp) begin failures++; $display("FAIL end_wrap_load s%0d: lat %0d data %0h expected 1/%0h", s, lat, got, exp); end
    end
`else
    ea = '0;
    checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL end_idle s%0d: got %0d expected %0d", s, dbg_state, ST_IDLE); end
    repeat (6) next_cycle();
    checks++; if (n_loads - l0 !== len || n_dones - d0 !== 1) begin failures++; $display("FAIL end_no_retrigger s%0d: loads %0d dones %0d expected %0d/1 addr %0h", s, n_loads - l0, n_dones - d0, len, ea); end
`endif
  endtask

  task automatic test_done_ignored();
    int lat, l0;
    logic [DW-1:0] got, exp;
    apply_reset();
    song = 2'd2;
    next_cycle();
    play = 1'b1;
    next_cycle();
    note_done = 1'b1;                  // held through FETCH, RDATA and LOAD
    l0 = n_loads;
    wait_load(lat);
    got = {note_to_load, duration_to_load};
    exp = entry(2, 0);
    checks++; if (lat !== 2 || got !== exp) begin failures++; $display("FAIL ign_load: lat %0d data %0h expected 2/%0h", lat, got, exp); end
    next_cycle();
    note_done = 1'b0;
    repeat (5) next_cycle();
    @(negedge clk);
    checks++; if (n_loads - l0 !== 1 || dbg_state !== ST_PLAYING) begin failures++; $display("FAIL ign_hold: loads %0d state %0d expected 1/%0d", n_loads - l0, dbg_state, ST_PLAYING); end
  endtask

  task automatic test_pause();
    int lat, l0;
    logic [DW-1:0] got, exp;
    logic [AW-1:0] ea;
    apply_reset();
    song = 2'd2;
    next_cycle();
    play = 1'b1;
    next_cycle();
    wait_load(lat);
    got = {note_to_load, duration_to_load};
    exp = entry(2, 0);
    checks++; if (lat !== 2 || got !== exp) begin failures++; $display("FAIL pause_first: lat %0d data %0h expected 2/%0h", lat, got, exp); end
    next_cycle();
    play = 1'b0;
    l0 = n_loads;
    pulse_note_done();
    repeat (4) next_cycle();
    @(negedge clk);
    ea = addr_of(2, 0);
    checks++; if (n_loads !== l0 || dbg_state !== ST_PLAYING || rom_addr !== ea) begin failures++; $display("FAIL pause_hold: loads %0d state %0d addr %0h expected %0d/%0d/%0h", n_loads - l0, dbg_state, rom_addr, 0, ST_PLAYING, ea); end
    next_cycle();
    play = 1'b1;
    next_cycle();
    pulse_note_done();
    wait_load(lat);
    got = {note_to_load, duration_to_load};
    exp = entry(2, 1);
    checks++; if (lat !== 2 || got !== exp) begin failures++; $display("FAIL pause_resume_rest: lat %0d data %0h expected 2/%0h", lat, got, exp); end
    next_cycle();
  endtask

  task automatic test_song_change();
    int lat, d0;
    logic [DW-1:0] got, exp;
    logic [AW-1:0] ea;
    apply_reset();
    song = 2'd1;
    next_cycle();
    play = 1'b1;
    next_cycle();
    wait_load(lat);
    next_cycle();
    pulse_note_done();
    wait_load(lat);
    got = {note_to_load, duration_to_load};
    exp = entry(1, 1);
    checks++; if (lat !== 2 || got !== exp) begin failures++; $display("FAIL chg_second: lat %0d data %0h expected 2/%0h", lat, got, exp); end
    next_cycle();
    d0 = n_dones;
    song = 2'd2;
    note_done = 1'b1;
    next_cycle();
    note_done = 1'b0;
    @(negedge clk);
    ea = addr_of(2, 0);
    checks++; if (rom_addr !== ea) begin failures++; $display("FAIL chg_addr: got %0h expected %0h", rom_addr, ea); end
    next_cycle();
    wait_load(lat);
    got = {note_to_load, duration_to_load};
    exp = entry(2, 0);
    checks++; if (lat !== 1 || got !== exp) begin failures++; $display("FAIL chg_load: lat %0d data %0h expected 1/%0h", lat, got, exp); end
    checks++; if (n_dones !== d0) begin failures++; $display("FAIL chg_no_done: got %0d expected 0", n_dones - d0); end
    next_cycle();
  endtask

  task automatic test_full_song();
    int lat, l0, d0;
    logic sd, exp_sd;
    logic [DW-1:0] got, exp;
    logic [AW-1:0] ea;
    apply_reset();
    song = 2'd3;
    next_cycle();
    l0 = n_loads; d0 = n_dones;
    play = 1'b1;
    next_cycle();
    for (int k = 0; k < NENT; k++) begin
      wait_load(lat);
      got = {note_to_load, duration_to_load};
      exp = entry(3, k);
      checks++; if (lat !== 2 || got !== exp) begin failures++; $display("FAIL full_load i%0d: lat %0d data %0h expected 2/%0h", k, lat, got, exp); end
      next_cycle();
      repeat ($urandom_range(0, 2)) next_cycle();
      note_done = 1'b1;
      @(negedge clk);
      sd = song_done;
      next_cycle();
      note_done = 1'b0;
      exp_sd = (k == NENT - 1);
      checks++; if (sd !== exp_sd) begin failures++; $display("FAIL full_done i%0d: got %0b expected %0b", k, sd, exp_sd); end
    end
    @(negedge clk);
`ifdef SEQ_LOOP_EN
    ea = addr_of(3, 0);
    checks++; if (rom_addr !== ea) begin failures++; $display("FAIL full_wrap_addr: got %0h expected %0h", rom_addr, ea); end
    next_cycle();
    wait_load(lat);
    got = {note_to_load, duration_to_load};
    exp = entry(3, 0);
    checks++; if (lat !== 1 || got !== exp) begin failures++; $display("FAIL full_wrap_load: lat %0d data %0h expected 1/%0h", lat, got, exp); end
    next_cycle();
`else
    ea = '0;
    checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL full_idle: got %0d expected %0d addr %0h", dbg_state, ST_IDLE, ea); end
    repeat (4) next_cycle();
    checks++; if (n_loads - l0 !== NENT) begin failures++; $display("FAIL full_loads: got %0d expected %0d", n_loads - l0, NENT); end
`endif
    checks++; if (n_dones - d0 !== 1) begin failures++; $display("FAIL full_done_count: got %0d expected 1", n_dones - d0); end
  endtask

  task automatic test_reset_mid();
    int lat, l0, d0;
    logic [DW-1:0] got, exp;
    apply_reset();
    song = 2'd1;
    next_cycle();
    play = 1'b1;
    next_cycle();
    wait_load(lat);
    next_cycle();
    pulse_note_done();                 // now in FETCH of entry 1
    next_cycle();                      // RDATA
    l0 = n_loads; d0 = n_dones;
    reset_n = 1'b0;
    #1;
    checks++; if (load_new_note !== 1'b0 || song_done !== 1'b0) begin failures++; $display("FAIL rmid_strobes: load %0b done %0b expected 0/0", load_new_note, song_done); end
    checks++; if (note_to_load !== '0 || duration_to_load !== '0) begin failures++; $display("FAIL rmid_note_dur: got %0d/%0d expected 0/0", note_to_load, duration_to_load); end
    checks++; if (rom_addr !== '0 || dbg_state !== ST_IDLE) begin failures++; $display("FAIL rmid_addr_state: addr %0h state %0d expected 0/%0d", rom_addr, dbg_state, ST_IDLE); end
    @(negedge clk);
    reset_n = 1'b1;                    // play still high
    repeat (8) next_cycle();
    @(negedge clk);
    checks++; if (n_loads !== l0 || n_dones !== d0 || dbg_state !== ST_IDLE) begin failures++; $display("FAIL rmid_no_restart: loads %0d dones %0d state %0d expected 0/0/%0d", n_loads - l0, n_dones - d0, dbg_state, ST_IDLE); end
    next_cycle();
    play = 1'b0;
    next_cycle();
    play = 1'b1;
    next_cycle();
    wait_load(lat);
    got = {note_to_load, duration_to_load};
    exp = entry(1, 0);
    checks++; if (lat !== 2 || got !== exp) begin failures++; $display("FAIL rmid_restart: lat %0d data %0h expected 2/%0h", lat, got, exp); end
    next_cycle();
  endtask

  task automatic test_exclusive();
    checks++; if (n_both !== 0) begin failures++; $display("FAIL load_and_done_overlap: got %0d cycles expected 0", n_both); end
  endtask

  // ---------------- sequencing and report ----------------
  initial begin
    reset_n = 1'b0; play = 1'b0; note_done = 1'b0; song = '0;
    fill_rom();
    test_reset();
    test_first_load();
    test_song_end(0);
    test_song_end(1);
    test_song_end(2);
    test_done_ignored();
    test_pause();
    test_song_change();
    test_full_song();
    test_reset_mid();
    test_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run exceeded time limit, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
